// File: rtl/piarb_ll_walker.sv
// piarb_ll_walker
//   Walks one packet's buffer chain in the PIARB buffer linked list. A descriptor
//   (head pointer + buffer count) is turned into a stream of buffer pointers, in
//   chain order, on a ready/valid output marked with SOP/EOP. Each successor
//   pointer is fetched through the linked list's read port (fixed 3-cycle latency).
//   This block is the only master of that read port.
// Ports
//   clk, rst_n                         clock, async active-low reset
//   desc_valid/desc_ready              descriptor handshake (ready == idle)
//   desc_head_ptr, desc_buf_cnt        first buffer, number of buffers
//   desc_err                           pulse: zero-count descriptor dropped
//   buf_req, buf_req_ptr               linked-list read request (1-cycle pulse)
//   buf_ack_valid, buf_ack_ptr         linked-list read return
//   ack_err                            pulse: ack seen with nothing outstanding
//   out_valid/out_ready                buffer pointer handshake
//   out_ptr, out_sop, out_eop          buffer pointer and packet markers
//   busy                               walker not idle
module piarb_ll_walker #(
    parameter int BUF_NBITS = 8,
    parameter int CNT_NBITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [BUF_NBITS-1:0] desc_head_ptr,
    input  logic [CNT_NBITS-1:0] desc_buf_cnt,
    output logic                 desc_err,
    output logic                 buf_req,
    output logic [BUF_NBITS-1:0] buf_req_ptr,
    input  logic                 buf_ack_valid,
    input  logic [BUF_NBITS-1:0] buf_ack_ptr,
    output logic                 ack_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUF_NBITS-1:0] out_ptr,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OUT  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [CNT_NBITS-1:0] CNT_ONE = {{(CNT_NBITS-1){1'b0}}, 1'b1};

    logic [1:0]           state;
    logic [BUF_NBITS-1:0] cur_ptr;
    logic [BUF_NBITS-1:0] nxt_ptr;
    logic [CNT_NBITS-1:0] rem;
    logic                 sop_flag;
    logic                 entry;     // first cycle of the current OUT beat
    logic                 req_pend;  // linked-list read in flight
    logic                 ack_got;   // successor already captured in nxt_ptr

    logic in_out, last, ack_ok, hs;

    assign in_out      = (state == S_OUT);
    assign last        = (rem == CNT_ONE);
    assign ack_ok      = buf_ack_valid & req_pend;
    assign hs          = in_out & out_ready;

    assign desc_ready  = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = in_out;
    assign out_ptr     = cur_ptr;
    assign out_sop     = in_out & sop_flag;
    assign out_eop     = in_out & last;
    // The successor fetch is launched once, on the beat's entry cycle, so it
    // overlaps with any downstream stall.
    assign buf_req     = in_out & entry & ~last;
    assign buf_req_ptr = cur_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur_ptr  <= '0;
            nxt_ptr  <= '0;
            rem      <= '0;
            sop_flag <= 1'b0;
            entry    <= 1'b0;
            req_pend <= 1'b0;
            ack_got  <= 1'b0;
            desc_err <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            desc_err <= 1'b0;
            ack_err  <= buf_ack_valid & ~req_pend;
            entry    <= 1'b0;
            if (ack_ok)  req_pend <= 1'b0;
            if (buf_req) req_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (desc_valid) begin
                        if (desc_buf_cnt == '0) begin
                            desc_err <= 1'b1;
                        end else begin
                            cur_ptr  <= desc_head_ptr;
                            rem      <= desc_buf_cnt;
                            sop_flag <= 1'b1;
                            entry    <= 1'b1;
                            ack_got  <= 1'b0;
                            state    <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (hs) begin
                        if (last) begin
                            sop_flag <= 1'b0;
                            state    <= S_IDLE;
                        end else if (ack_got || ack_ok) begin
                            // A stored successor wins; a same-cycle ack is used directly.
                            cur_ptr  <= ack_got ? nxt_ptr : buf_ack_ptr;
                            rem      <= rem - CNT_ONE;
                            sop_flag <= 1'b0;
                            entry    <= 1'b1;
                            ack_got  <= 1'b0;
                        end else begin
                            state    <= S_WAIT;
                        end
                    end else if (ack_ok) begin
                        nxt_ptr <= buf_ack_ptr;
                        ack_got <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ack_ok) begin
                        cur_ptr  <= buf_ack_ptr;
                        rem      <= rem - CNT_ONE;
                        sop_flag <= 1'b0;
                        entry    <= 1'b1;
                        state    <= S_OUT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piarb_ll_walker.sv
// Bench for piarb_ll_walker: linked-list memory model with 3-cycle read latency,
// expected-stream scoreboard built by walking the chain, directed scenarios and
// a randomized phase.
module tb_piarb_ll_walker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       desc_valid, desc_ready, desc_err;
    logic [7:0] desc_head_ptr, desc_buf_cnt;
    logic       buf_req, buf_ack_valid, ack_err;
    logic [7:0] buf_req_ptr, buf_ack_ptr;
    logic       out_valid, out_ready, out_sop, out_eop, busy;
    logic [7:0] out_ptr;

    piarb_ll_walker #(.BUF_NBITS(8), .CNT_NBITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_head_ptr(desc_head_ptr), .desc_buf_cnt(desc_buf_cnt),
        .desc_err(desc_err),
        .buf_req(buf_req), .buf_req_ptr(buf_req_ptr),
        .buf_ack_valid(buf_ack_valid), .buf_ack_ptr(buf_ack_ptr),
        .ack_err(ack_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ptr(out_ptr), .out_sop(out_sop), .out_eop(out_eop),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    logic [7:0] ll_mem [256];
    logic       pv [3];
    logic [7:0] pp [3];
    int         outstanding = 0;
    bit         inj_ack = 0;
    logic [7:0] exp_ptr_q [$];
    bit         exp_sop_q [$];
    bit         exp_eop_q [$];
    int         hs_cyc [$];
    logic [7:0] req_q [$];
    int         acc_cyc = 0;
    int         nreq = 0, exp_nreq = 0;
    bit         exp_derr = 0, exp_aerr = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_ptr;
    bit         prev_sop, prev_eop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: checks on registered outputs, then the linked-list model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("desc_err", desc_err, exp_derr);
        chk("ack_err", ack_err, exp_aerr);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ptr", out_ptr, prev_ptr);
            chk("hold_sop", out_sop, prev_sop);
            chk("hold_eop", out_eop, prev_eop);
        end
        if (buf_req) begin
            chk("req_in_out", out_valid, 1);
            if (exp_ptr_q.size() != 0) begin
                chk("req_ptr", buf_req_ptr, exp_ptr_q[0]);
                chk("req_not_last", exp_eop_q[0], 0);
            end
        end
        buf_ack_valid = pv[2] | inj_ack;
        buf_ack_ptr   = pv[2] ? pp[2] : 8'h33;
        exp_aerr      = buf_ack_valid && (outstanding == 0);
        if (pv[2]) outstanding--;
        pv[2] = pv[1]; pp[2] = pp[1];
        pv[1] = pv[0]; pp[1] = pp[0];
        pv[0] = buf_req;
        pp[0] = ll_mem[buf_req_ptr];
        if (buf_req) begin
            outstanding++;
            nreq++;
            req_q.push_back(buf_req_ptr);
        end
        inj_ack = 0;
    endtask

    // Inputs for the current cycle, plus acceptance / handshake scoring.
    task automatic drive(input bit dv, input logic [7:0] head, input logic [7:0] cnt, input bit ordy);
        logic [7:0] p;
        desc_valid    = dv;
        desc_head_ptr = head;
        desc_buf_cnt  = cnt;
        out_ready     = ordy;
        exp_derr      = dv && desc_ready && (cnt == 0);
        if (dv && desc_ready && cnt != 0) begin
            acc_cyc = cyc;
            exp_nreq += int'(cnt) - 1;
            p = head;
            for (int i = 0; i < int'(cnt); i++) begin
                exp_ptr_q.push_back(p);
                exp_sop_q.push_back(i == 0);
                exp_eop_q.push_back(i == int'(cnt) - 1);
                p = ll_mem[p];
            end
        end
        if (out_valid && ordy) begin
            hs_cyc.push_back(cyc);
            if (exp_ptr_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("out_ptr", out_ptr, exp_ptr_q.pop_front());
                chk("out_sop", out_sop, exp_sop_q.pop_front());
                chk("out_eop", out_eop, exp_eop_q.pop_front());
            end
        end
        prev_stall = out_valid && !ordy;
        prev_ptr   = out_ptr;
        prev_sop   = out_sop;
        prev_eop   = out_eop;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((busy || exp_ptr_q.size() != 0) && n < limit) begin
            tick();
            drive(0, 8'h00, 8'h00, 1);
            n++;
        end
        chk("drain_timeout", n < limit, 1);
        chk("queue_empty", exp_ptr_q.size(), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin pv[i] = 0; pp[i] = 0; end
        outstanding = 0;
        exp_derr = 0; exp_aerr = 0; prev_stall = 0; inj_ack = 0;
        buf_ack_valid = 0;
        exp_ptr_q.delete(); exp_sop_q.delete(); exp_eop_q.delete();
    endtask

    initial begin
        int n0, sc, n;
        bit w, ordy;
        logic [7:0] c;
        for (int i = 0; i < 256; i++) ll_mem[i] = 8'($urandom);
        ll_mem[8'h05] = 8'h09;
        ll_mem[8'h09] = 8'h02;
        rst_n = 0; desc_valid = 0; desc_head_ptr = 0; desc_buf_cnt = 0;
        out_ready = 0; buf_ack_ptr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_buf_req", buf_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {desc_err, ack_err, out_sop, out_eop}, 0);
        chk("rst_ptrs", {out_ptr, buf_req_ptr}, 0);
        rst_n = 1;

        // 1) single buffer
        n0 = nreq;
        tick(); drive(1, 8'h05, 8'd1, 1);
        tick(); chk("t1_valid", out_valid, 1); chk("t1_ready_low", desc_ready, 0);
        drive(0, 8'h00, 8'h00, 1);
        tick(); chk("t1_ready", desc_ready, 1); drive(0, 8'h00, 8'h00, 1);
        drain(50);
        chk("t1_nreq", nreq - n0, 0);

        // 2) three-buffer chain, ready tied high: beats 4 cycles apart
        n0 = nreq; hs_cyc.delete(); req_q.delete();
        tick(); drive(1, 8'h05, 8'd3, 1);
        drain(100);
        chk("t2_nbeats", hs_cyc.size(), 3);
        for (int i = 0; i < hs_cyc.size() && i < 3; i++)
            chk("t2_latency", hs_cyc[i] - acc_cyc, 1 + 4 * i);
        chk("t2_nreq", nreq - n0, 2);
        chk("t2_nreqq", req_q.size(), 2);
        if (req_q.size() == 2) begin
            chk("t2_req0", req_q[0], 8'h05);
            chk("t2_req1", req_q[1], 8'h09);
        end

        // 3) same chain, 6-cycle stall on each beat
        n0 = nreq; hs_cyc.delete(); sc = 0; n = 0;
        tick(); drive(1, 8'h05, 8'd3, 0);
        while ((busy || exp_ptr_q.size() != 0) && n < 200) begin
            tick();
            if (out_valid) sc++;
            ordy = (sc >= 7);
            drive(0, 8'h00, 8'h00, ordy);
            if (out_valid && ordy) sc = 0;
            n++;
        end
        chk("t3_timeout", n < 200, 1);
        chk("t3_nbeats", hs_cyc.size(), 3);
        for (int i = 1; i < hs_cyc.size() && i < 3; i++)
            chk("t3_gap", hs_cyc[i] - hs_cyc[i-1], 7);
        chk("t3_nreq", nreq - n0, 2);

        // 4) zero-count descriptor dropped, next one accepted
        n0 = nreq;
        tick(); drive(1, 8'h44, 8'd0, 1);
        tick(); chk("t4_derr", desc_err, 1); chk("t4_noval", out_valid, 0);
        chk("t4_ready", desc_ready, 1);
        drive(1, 8'h07, 8'd1, 1);
        tick(); chk("t4_next", out_valid, 1); drive(0, 8'h00, 8'h00, 1);
        drain(50);
        chk("t4_nreq", nreq - n0, 0);

        // 5) stray ack while idle
        inj_ack = 1;
        tick(); drive(0, 8'h00, 8'h00, 1);
        tick(); chk("t5_aerr", ack_err, 1); chk("t5_busy", busy, 0);
        chk("t5_noval", out_valid, 0); chk("t5_ready", desc_ready, 1);
        drive(0, 8'h00, 8'h00, 1);
        tick(); chk("t5_aerr_clr", ack_err, 0); drive(0, 8'h00, 8'h00, 1);

        // 6) reset in WAIT, then a fresh 2-buffer walk
        tick(); drive(1, 8'h05, 8'd3, 1);
        n = 0; w = 0;
        do begin
            tick();
            w = busy && !out_valid;
            drive(0, 8'h00, 8'h00, 1);
            n++;
        end while (!w && n < 20);
        chk("t6_wait", w, 1);
        rst_n = 0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_ready", desc_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_pulses", {buf_req, desc_err, ack_err, out_sop, out_eop}, 0);
        model_reset();
        exp_nreq -= 1;  // aborted 3-buffer packet only issued its first request
        tick(); drive(0, 8'h00, 8'h00, 1);
        rst_n = 1;
        hs_cyc.delete();
        tick(); drive(1, 8'h09, 8'd2, 1);
        drain(100);
        chk("t6_nbeats", hs_cyc.size(), 2);

        // 7) maximum count
        tick(); drive(1, 8'($urandom), 8'd255, 1);
        drain(2000);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            inj_ack = ($urandom_range(0, 15) == 0) && (outstanding == 0);
            tick();
            c = ($urandom_range(0, 9) == 0) ? 8'd0 :
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(1, 7));
            drive($urandom_range(0, 2) == 0, 8'($urandom), c, $urandom_range(0, 3) != 0);
        end
        drain(500);
        tick(); drive(0, 8'h00, 8'h00, 1);
        chk("req_count", nreq, exp_nreq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
